// File: rtl/collatz_range.sv
// -----------------------------------------------------------------------------
// collatz_range
//   Collatz engine. On an accepted `go` it runs the Collatz iteration for
//   RAM_WORDS consecutive starting values (start, start+1, ... modulo 2^32).
//   Each sequence length goes into an internal RAM. `done` is raised once every
//   entry has been written. A separate read port returns RAM[n] one cycle
//   after `n` is applied. It works in any state.
//
//   Sequence length counts every value in the sequence, including the start
//   value and the final 1. Lengths saturate at 16'hFFFF. A start value of 0
//   never reaches 1, so it stores 16'hFFFF.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   go     in   run request, level-sampled only in IDLE or DONE
//   start  in   first starting value, latched when go is accepted
//   done   out  high once all RAM_WORDS results are written
//   n      in   read address into the result RAM
//   count  out  registered read data RAM[n], 1-cycle latency
// -----------------------------------------------------------------------------
module collatz_range #(
   parameter int RAM_WORDS     = 256,
   parameter int RAM_ADDR_BITS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     go,
   input  logic [31:0]              start,
   output logic                     done,
   input  logic [RAM_ADDR_BITS-1:0] n,
   output logic [15:0]              count
);

   localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);
   localparam logic [15:0]              C_SAT    = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ITER,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                   r_state;
   state_t                   w_next_state;
   logic [31:0]              r_base;
   logic [31:0]              r_v;
   logic [15:0]              r_c;
   logic [RAM_ADDR_BITS-1:0] r_i;
   logic [15:0]              r_mem [RAM_WORDS];

   logic                     w_iter_end;
   logic [31:0]              w_v_step;
   logic                     w_we;

   // The entry terminates on reaching 1 or on a saturated length.
   assign w_iter_end = (r_v == 32'd1) || (r_c == C_SAT);
   // 3v+1 is written as (v<<1)+v+1 and wraps modulo 2^32 by construction.
   assign w_v_step   = r_v[0] ? ((r_v << 1) + r_v + 32'd1) : (r_v >> 1);
   // Reset outranks a pending write, so an aborted WRITE cycle stores nothing.
   assign w_we       = (r_state == S_WRITE) && !reset;

   // NOTE: every output of this block is given a default first. That makes
   // each path through the case assign every signal, so no latches are inferred.
   always_comb begin
      w_next_state = r_state;
      done         = 1'b0;
      unique case (r_state)
         S_IDLE:  if (go) w_next_state = S_LOAD;
         S_LOAD:  w_next_state = S_ITER;
         S_ITER:  if (w_iter_end) w_next_state = S_WRITE;
         S_WRITE: w_next_state = (r_i == LAST_IDX) ? S_DONE : S_LOAD;
         S_DONE: begin
            done = 1'b1;
            if (go) w_next_state = S_LOAD;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments. Every register then
   // updates from the values that existed before the edge, whatever order the
   // statements are in.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_base  <= '0;
         r_v     <= '0;
         r_c     <= '0;
      end else begin
         r_state <= w_next_state;
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (go) begin
                  r_base <= start;
                  r_i    <= '0;
               end
            end
            S_LOAD: begin
               r_v <= r_base + 32'(r_i);
               r_c <= 16'd1;
            end
            S_ITER: begin
               if (!w_iter_end) begin
                  r_v <= w_v_step;
                  r_c <= r_c + 16'd1;
               end
            end
            S_WRITE: begin
               if (r_i != LAST_IDX) r_i <= r_i + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the result RAM has no reset. Clearing it would stop block-RAM
   // inference, and entries are meant to survive a reset anyway.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[r_i] <= r_c;
   end

   // Registered read. A write to the same address in the same cycle is not
   // visible here until the following cycle, so the old data is returned.
   always_ff @(posedge clk) begin
      if (reset) count <= '0;
      else       count <= r_mem[n];
   end

endmodule
